// File: rtl/cbc_pkg.sv
// Shared constants for the cbc_dig coefficient path: arbiter states,
// coefficient indices and the default charge-pump timing.
package cbc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_BOOT_RD  = 3'd1,
      ST_BOOT_CAP = 3'd2,
      ST_RD       = 3'd3,
      ST_CAP      = 3'd4,
      ST_WR       = 3'd5,
      ST_WR_END   = 3'd6
   } arb_state_e;

   localparam logic [1:0] COEF_XSET = 2'd0;
   localparam logic [1:0] COEF_P    = 2'd1;
   localparam logic [1:0] COEF_I    = 2'd2;
   localparam logic [1:0] COEF_D    = 2'd3;

   localparam int CP_CYCLES_DEF = 1500000;
   localparam int CP_W_DEF      = 21;

   // States in which the EEPROM chip select is driven active.
   function automatic logic is_eep_active(arb_state_e s);
      return (s == ST_BOOT_RD) || (s == ST_RD) || (s == ST_WR);
   endfunction

endpackage

// File: rtl/cp_timer.sv
// Charge-pump on-time counter: loads on start, counts down, and flags
// expiry for one cycle once CP_CYCLES cycles have elapsed since start.
module cp_timer #(
   parameter int CP_CYCLES = 1500000,
   parameter int CP_W      = 21
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clr,
   output logic expired
);

   localparam logic [CP_W-1:0] LOAD_VAL = CP_W'(CP_CYCLES - 1);

   logic [CP_W-1:0] cnt_q;
   logic            run_q;

   assign expired = run_q && (cnt_q == '0);

   // start wins over clr so a write can begin in the cycle the pump is idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         cnt_q <= LOAD_VAL;
         run_q <= 1'b1;
      end else if (clr || expired) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (run_q) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/eep_arb.sv
// Coefficient EEPROM sequencer: boot-loads the four coefficients, then
// arbitrates PID reads and command reads/writes round-robin.
module eep_arb
   import cbc_pkg::*;
#(
   parameter int CP_CYCLES = CP_CYCLES_DEF,
   parameter int CP_W      = CP_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pid_req,
   input  logic [1:0]  pid_addr,
   output logic        pid_gnt,
   output logic        pid_vld,
   input  logic        cmd_req,
   input  logic        cmd_wr,
   input  logic [1:0]  cmd_addr,
   input  logic [13:0] cmd_wdata,
   output logic        cmd_gnt,
   output logic        cmd_done,
   output logic [13:0] rd_data,
   output logic        coef_ld,
   output logic [1:0]  coef_idx,
   output logic [13:0] coef_data,
   output logic        boot_done,
   output logic [1:0]  eep_addr,
   output logic [13:0] eep_wdata,
   input  logic [13:0] eep_rd_data,
   output logic        eep_cs_n,
   output logic        eep_r_w_n,
   output logic        chrg_pmp_en,
   output logic [2:0]  dbg_state
);

   arb_state_e  state_q, state_d;
   logic        boot_done_q, boot_done_d;
   logic [1:0]  boot_idx_q;
   logic        ptr_q;
   logic        req_src_q;
   logic        req_wr_q;
   logic [1:0]  req_addr_q;
   logic [13:0] req_wdata_q;
   logic        pid_gnt_q, cmd_gnt_q, pid_vld_q, cmd_done_q;
   logic [13:0] rd_data_q;
   logic        coef_ld_q;
   logic [1:0]  coef_idx_q;
   logic [13:0] coef_data_q;
   logic [1:0]  eep_addr_q;
   logic [13:0] eep_wdata_q;
   logic        eep_cs_n_q, eep_r_w_n_q, chrg_q;
   logic        grant_ok, pid_win, cmd_win, rd_done;
   logic        cp_start, cp_clr, cp_expired;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!boot_done_q)                state_d = ST_BOOT_RD;
            else if (pid_gnt_q || cmd_gnt_q) state_d = req_wr_q ? ST_WR : ST_RD;
         end
         ST_BOOT_RD:  state_d = ST_BOOT_CAP;
         ST_BOOT_CAP: state_d = ST_IDLE;
         ST_RD:       state_d = ST_CAP;
         ST_CAP:      state_d = ST_IDLE;
         ST_WR:       if (cp_expired) state_d = ST_WR_END;
         ST_WR_END:   state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Grants are registered on the edge that lands in IDLE, so a held request
   // is accepted in the first IDLE cycle after boot or after a transaction.
   assign boot_done_d = boot_done_q || ((state_q == ST_BOOT_CAP) && (boot_idx_q == COEF_D));
   assign grant_ok    = (state_d == ST_IDLE) && boot_done_d;
   assign pid_win     = grant_ok && pid_req && (!cmd_req || !ptr_q);
   assign cmd_win     = grant_ok && cmd_req && (!pid_req || ptr_q);
   assign rd_done     = (state_q == ST_CAP);

   assign cp_start = (state_q == ST_IDLE) && (state_d == ST_WR);
   assign cp_clr   = (state_q != ST_WR);

   cp_timer #(
      .CP_CYCLES (CP_CYCLES),
      .CP_W      (CP_W)
   ) u_cp_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (cp_start),
      .clr     (cp_clr),
      .expired (cp_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         boot_done_q <= 1'b0;
         boot_idx_q  <= COEF_XSET;
         ptr_q       <= 1'b0;
         req_src_q   <= 1'b0;
         req_wr_q    <= 1'b0;
         req_addr_q  <= 2'd0;
         req_wdata_q <= 14'd0;
         pid_gnt_q   <= 1'b0;
         cmd_gnt_q   <= 1'b0;
         pid_vld_q   <= 1'b0;
         cmd_done_q  <= 1'b0;
         rd_data_q   <= 14'd0;
         coef_ld_q   <= 1'b0;
         coef_idx_q  <= 2'd0;
         coef_data_q <= 14'd0;
         eep_addr_q  <= 2'd0;
         eep_wdata_q <= 14'd0;
         eep_cs_n_q  <= 1'b1;
         eep_r_w_n_q <= 1'b1;
         chrg_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         boot_done_q <= boot_done_d;
         pid_gnt_q   <= pid_win;
         cmd_gnt_q   <= cmd_win;
         if (pid_win || cmd_win) begin
            req_src_q   <= cmd_win;
            req_wr_q    <= cmd_win && cmd_wr;
            req_addr_q  <= cmd_win ? cmd_addr : pid_addr;
            req_wdata_q <= cmd_wdata;
         end
         if (pid_req && cmd_req && (pid_win || cmd_win)) ptr_q <= ~ptr_q;
         if (state_q == ST_BOOT_CAP) boot_idx_q <= boot_idx_q + 2'd1;

         // Pin drivers decode the next state so they change cleanly with it.
         eep_cs_n_q  <= !is_eep_active(state_d);
         eep_r_w_n_q <= (state_d != ST_WR);
         chrg_q      <= (state_d == ST_WR);
         if (state_d == ST_BOOT_RD)                          eep_addr_q <= boot_idx_q;
         else if ((state_d == ST_RD) || (state_d == ST_WR)) eep_addr_q <= req_addr_q;
         if (state_d == ST_WR) eep_wdata_q <= req_wdata_q;

         pid_vld_q  <= rd_done && !req_src_q;
         cmd_done_q <= (rd_done && req_src_q) || (state_d == ST_WR_END);
         if (rd_done) rd_data_q <= eep_rd_data;

         coef_ld_q <= (state_q == ST_BOOT_CAP) || (state_d == ST_WR_END);
         if (state_q == ST_BOOT_CAP) begin
            coef_idx_q  <= boot_idx_q;
            coef_data_q <= eep_rd_data;
         end else if (state_d == ST_WR_END) begin
            coef_idx_q  <= req_addr_q;
            coef_data_q <= req_wdata_q;
         end
      end
   end

   assign pid_gnt     = pid_gnt_q;
   assign pid_vld     = pid_vld_q;
   assign cmd_gnt     = cmd_gnt_q;
   assign cmd_done    = cmd_done_q;
   assign rd_data     = rd_data_q;
   assign coef_ld     = coef_ld_q;
   assign coef_idx    = coef_idx_q;
   assign coef_data   = coef_data_q;
   assign boot_done   = boot_done_q;
   assign eep_addr    = eep_addr_q;
   assign eep_wdata   = eep_wdata_q;
   assign eep_cs_n    = eep_cs_n_q;
   assign eep_r_w_n   = eep_r_w_n_q;
   assign chrg_pmp_en = chrg_q;
   assign dbg_state   = state_q;

endmodule

// File: doc/eep_arb.md
# eep_arb

Sequencer and arbiter for the shared coefficient EEPROM in `cbc_dig`. After reset it boot-loads the four stored coefficient words: xset, P, I and D. It then serves single-word read requests from the PID math sequencer and read/write requests from command mode. Requests are arbitrated round-robin. The block owns all EEPROM pins and drives the write charge-pump timing.

## Interface
- `CP_CYCLES`, default 1500000: charge-pump on-time per write, in clk cycles (3 ms at 500 MHz).
- `CP_W`, default 21: width of the charge-pump counter; must satisfy 2^CP_W > CP_CYCLES.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pid_req`  in  1  PID read request; level, held until `pid_gnt`.
- `pid_addr`  in  2  PID read address.
- `pid_gnt`  out  1  one-cycle accept pulse for the PID request.
- `pid_vld`  out  1  one-cycle pulse; `rd_data` holds the PID result.
- `cmd_req`  in  1  command request; level, held until `cmd_gnt`.
- `cmd_wr`  in  1  1 selects write, 0 selects read.
- `cmd_addr`  in  2  command address.
- `cmd_wdata`  in  14  command write data.
- `cmd_gnt`  out  1  one-cycle accept pulse for the command request.
- `cmd_done`  out  1  one-cycle completion pulse for the command (read or write).
- `rd_data`  out  14  registered read result, shared by both requesters.
- `coef_ld`  out  1  one-cycle pulse: load `coef_data` into the coefficient register selected by `coef_idx`.
- `coef_idx`  out  2  coefficient index: 0 = xset, 1 = P, 2 = I, 3 = D.
- `coef_data`  out  14  coefficient value.
- `boot_done`  out  1  high once boot-load completes.
- `eep_addr`  out  2  EEPROM address.
- `eep_wdata`  out  14  EEPROM write data (drives `dst`).
- `eep_rd_data`  in  14  EEPROM read data; valid the cycle after `eep_cs_n` is sampled low.
- `eep_cs_n`  out  1  EEPROM chip select, active low.
- `eep_r_w_n`  out  1  EEPROM direction: 1 = read, 0 = write.
- `chrg_pmp_en`  out  1  EEPROM write charge pump enable.

## Operation
- Reset values of all outputs:
  - `eep_cs_n`=1 and `eep_r_w_n`=1.
  - All other outputs 0.
  - Internal state: BOOT, boot index 0, round-robin pointer favours PID.
- States: BOOT_RD, BOOT_CAP, IDLE, RD, CAP, WR, WR_END.
- Boot sequence:
  - Reads addresses 0, 1, 2, 3 in order, one word per BOOT_RD/BOOT_CAP pair.
  - Each word produces a `coef_ld` pulse with `coef_idx` = address.
  - `boot_done` sets with the 4th `coef_ld` and holds until reset.
  - No grants are issued before `boot_done`.
- Arbitration in IDLE:
  - Only one requester active: it is granted.
  - Both active: the pointer side is granted, and the pointer then flips to the other side.
  - Addr, wr and wdata are registered at grant.
  - No grant is issued outside IDLE; requests are simply held by the requester.
- Read path: RD drives `eep_cs_n`=0, `eep_r_w_n`=1. CAP samples `eep_rd_data` into `rd_data`.
- Write path:
  - WR drives `eep_cs_n`=0, `eep_r_w_n`=0, `chrg_pmp_en`=1, with `eep_addr`/`eep_wdata` stable for exactly CP_CYCLES cycles.
  - WR_END releases all three, pulses `cmd_done`, and pulses `coef_ld` with `coef_idx`=addr and `coef_data`=wdata, so live coefficients track the EEPROM.
- PID requests are always reads; no write path exists for PID.
- Reset asserted mid-operation:
  - `chrg_pmp_en` and `eep_cs_n` go inactive immediately (asynchronously).
  - Any in-flight write is abandoned.
  - Boot reruns after reset is released.

## Timing
- Grant at cycle T. Read: RD at T+1, CAP at T+2; `rd_data` and `pid_vld`/`cmd_done` at T+3. IDLE resumes at T+3, so a new grant is possible in T+3.
- Write: WR occupies T+1 .. T+CP_CYCLES; WR_END at T+CP_CYCLES+1; IDLE at T+CP_CYCLES+2.
- Boot: reset released before cycle 0. Read k has BOOT_RD at 3k+1, BOOT_CAP at 3k+2, `coef_ld` at 3k+3. `boot_done` is high from cycle 12; the first grant can occur at cycle 12.
- `rd_data` holds its value until the next read completes.
- Output register conventions:
  - `eep_*` outputs and `chrg_pmp_en` are registered decodes of the next state (glitch-free).
  - Pulse outputs are registered.

## Structure
- Constants for the shared `cbc_pkg`:
  - State enum.
  - Coefficient indices XSET=0, P=1, I=2, D=3.
  - Default CP_CYCLES.
- One sub-module, `cp_timer`:
  - Loadable down-counter, CP_W bits.
  - Inputs `start` and `clr`; output `expired`, a one-cycle pulse after CP_CYCLES cycles.
  - Cleared asynchronously by `rst`.

## Test plan
- Boot: EEPROM preloaded with 0x0123, 0x0400, 0x0080, 0x0010 → four `coef_ld` pulses at cycles 3, 6, 9, 12 with idx 0..3 and those values; `boot_done`=1 at cycle 12; a `pid_req` held from cycle 0 is granted at cycle 12.
- PID read addr 2 → `pid_gnt` at T, `eep_cs_n` low at T+1 only, `pid_vld` at T+3 with `rd_data`=0x0080.
- Command write addr 1, data 0x1FFF, CP_CYCLES=20 → `chrg_pmp_en` high for exactly 20 cycles; then `cmd_done` and `coef_ld` (idx 1, 0x1FFF); a following read of addr 1 returns 0x1FFF.
- Contention, both requests held → grants alternate PID, CMD, PID, CMD; a `pid_req` raised during a write waits and is granted at T+CP_CYCLES+2.
- `rst` pulsed mid-write → `chrg_pmp_en`=0 and `eep_cs_n`=1 within the reset cycle; no `cmd_done`; boot reruns and reloads the unmodified old value.
